// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Imported by the arbiter top and its counter sub-module.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF   = 64;
    localparam int unsigned MAX_WAIT_DEF = 4;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned WAIT_W       = 8;

    typedef enum logic [1:0] {
        CORE_OWN   = 2'd0,
        HOST_WAIT  = 2'd1,
        HOST_FORCE = 2'd2
    } arb_state_e;

    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    // count up, clear wins over increment, hold at maximum
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage and a host port.
// Core has priority; a starved host gets one forced slot with a stall.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_re_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_stall_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CNT_W-1:0]  force_cnt_o
);

    arb_state_e        state_q;
    owner_e            rd_owner_q;
    logic              rvalid_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              core_busy;
    logic              force_slot;
    logic              blocked;
    logic              wait_hit;

    assign core_busy  = core_re_i | core_we_i;
    assign force_slot = (state_q == HOST_FORCE);
    assign blocked    = host_req_i & core_busy & ~force_slot;
    assign wait_hit   = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    assign host_gnt_o   = ~rst_i & host_req_i & (force_slot | ~core_busy);
    assign core_stall_o = ~rst_i & force_slot;

    // rd_data is a pass-through; only the valid strobe is owner-qualified
    assign core_rdata_o  = mem_rdata_i;
    assign host_rdata_o  = mem_rdata_i;
    assign host_rvalid_o = ~rst_i & rvalid_q & (rd_owner_q == HOST);

    // port mux: a granted host fully replaces the core request
    always_comb begin
        mem_re_o    = core_re_i;
        mem_we_o    = core_we_i;
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
        if (host_gnt_o) begin
            mem_re_o    = ~host_we_i;
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
        end
    end

    // ownership FSM plus registered read-owner and rvalid tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CORE_OWN;
            rd_owner_q <= CORE;
            rvalid_q   <= 1'b0;
        end else begin
            case (state_q)
                CORE_OWN, HOST_WAIT: begin
                    if (blocked) begin
                        state_q <= wait_hit ? HOST_FORCE : HOST_WAIT;
                    end else begin
                        state_q <= CORE_OWN;
                    end
                end
                default: state_q <= CORE_OWN;
            endcase
            rvalid_q <= host_gnt_o & ~host_we_i;
            if (mem_re_o) begin
                rd_owner_q <= host_gnt_o ? HOST : CORE;
            end
        end
    end

    sat_counter #(
        .W(WAIT_W)
    ) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (~blocked | wait_hit),
        .inc_i (blocked),
        .cnt_o (wait_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_force_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (force_slot),
        .cnt_o (force_cnt_o)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus a forced-slot
// saturation sequence run against a second instance with CNT_W=2.
module tb_dmem_arbiter;

    typedef struct {
        logic        rst;
        logic        cre;
        logic [7:0]  caddr;
        logic        hreq;
        logic        hwe;
        logic [7:0]  haddr;
        logic [63:0] hwd;
        logic        e_gnt;
        logic        e_stall;
        logic        e_rv;
        logic        chk_hd;
        logic [63:0] e_hd;
        logic        chk_cd;
        logic [63:0] e_cd;
        logic [15:0] e_fc;
    } vec_t;

    logic        clk;
    logic        rst_i;
    logic        core_re_i;
    logic        core_we_i;
    logic [7:0]  core_addr_i;
    logic [63:0] core_wdata_i;
    logic [63:0] core_rdata_o;
    logic        core_stall_o;
    logic        host_req_i;
    logic        host_we_i;
    logic [7:0]  host_addr_i;
    logic [63:0] host_wdata_i;
    logic        host_gnt_o;
    logic        host_rvalid_o;
    logic [63:0] host_rdata_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [63:0] mem_rdata_i;
    logic [15:0] force_cnt_o;

    logic [63:0] s_core_rdata;
    logic        s_stall;
    logic        s_gnt;
    logic        s_rvalid;
    logic [63:0] s_host_rdata;
    logic        s_re;
    logic        s_we;
    logic [7:0]  s_addr;
    logic [63:0] s_wdata;
    logic [1:0]  s_force_cnt;

    logic [63:0] mem [0:255];
    logic        preload;
    int          n_vec;
    int          n_err;
    vec_t        vecs[$];

    dmem_arbiter #(
        .ADDR_W(8), .DATA_W(64), .MAX_WAIT(4), .CNT_W(16)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .core_re_i    (core_re_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_rdata_o (core_rdata_o),
        .core_stall_o (core_stall_o),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_gnt_o   (host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o (host_rdata_o),
        .mem_re_o     (mem_re_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .force_cnt_o  (force_cnt_o)
    );

    dmem_arbiter #(
        .ADDR_W(8), .DATA_W(64), .MAX_WAIT(4), .CNT_W(2)
    ) u_sat (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .core_re_i    (core_re_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_rdata_o (s_core_rdata),
        .core_stall_o (s_stall),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_gnt_o   (s_gnt),
        .host_rvalid_o(s_rvalid),
        .host_rdata_o (s_host_rdata),
        .mem_re_o     (s_re),
        .mem_we_o     (s_we),
        .mem_addr_o   (s_addr),
        .mem_wdata_o  (s_wdata),
        .mem_rdata_i  (mem_rdata_i),
        .force_cnt_o  (s_force_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous data memory model with one-cycle read latency
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'h0;
            mem[8'h20]  <= 64'h5;
            mem[8'h30]  <= 64'h7;
            mem_rdata_i <= 64'h0;
        end else begin
            if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
            if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
        end
    end

    function automatic vec_t mk(
        input logic rst, input logic cre, input logic [7:0] caddr,
        input logic hreq, input logic hwe, input logic [7:0] haddr,
        input logic [63:0] hwd, input logic e_gnt, input logic e_stall,
        input logic e_rv, input logic chk_hd, input logic [63:0] e_hd,
        input logic chk_cd, input logic [63:0] e_cd, input logic [15:0] e_fc
    );
        vec_t v;
        v.rst = rst; v.cre = cre; v.caddr = caddr;
        v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
        v.e_gnt = e_gnt; v.e_stall = e_stall; v.e_rv = e_rv;
        v.chk_hd = chk_hd; v.e_hd = e_hd;
        v.chk_cd = chk_cd; v.e_cd = e_cd; v.e_fc = e_fc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        preload = 1'b1;
        rst_i = 1'b1;
        core_re_i = 1'b0; core_we_i = 1'b0;
        core_addr_i = 8'h0; core_wdata_i = 64'h0;
        host_req_i = 1'b0; host_we_i = 1'b0;
        host_addr_i = 8'h0; host_wdata_i = 64'h0;

        // reset held with both sides requesting
        vecs.push_back(mk(1,1,8'h00, 1,0,8'h10,0, 0,0,0, 0,0, 0,0, 0));
        vecs.push_back(mk(1,1,8'h00, 1,0,8'h10,0, 0,0,0, 0,0, 0,0, 0));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00,0, 0,0,0, 0,0, 0,0, 0));
        // free-slot write then back-to-back read
        vecs.push_back(mk(0,0,8'h00, 1,1,8'h10,64'hDEAD_BEEF, 1,0,0, 0,0, 0,0, 0));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'h10,0, 1,0,0, 0,0, 0,0, 0));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00,0, 0,0,1, 1,64'hDEAD_BEEF, 0,0, 0));
        // starvation: core reads continuously, host forced in cycle 4
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,8'h00, 1,0,8'h30,0, 0,0,0, 0,0, 0,0, 0));
        vecs.push_back(mk(0,1,8'h00, 1,0,8'h30,0, 1,1,0, 0,0, 0,0, 0));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00,0, 0,0,1, 1,64'h7, 0,0, 1));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00,0, 0,0,0, 0,0, 0,0, 1));
        // read ownership: core reads 0x20 at N, forced host read 0x30 at N+1
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,8'h20, 1,0,8'h30,0, 0,0,0, 0,0, 0,0, 1));
        vecs.push_back(mk(0,1,8'h20, 1,0,8'h30,0, 1,1,0, 0,0, 1,64'h5, 1));
        vecs.push_back(mk(0,1,8'h20, 0,0,8'h00,0, 0,0,1, 1,64'h7, 0,0, 2));
        // host abandons after 2 blocked cycles
        vecs.push_back(mk(0,1,8'h00, 1,0,8'h30,0, 0,0,0, 0,0, 0,0, 2));
        vecs.push_back(mk(0,1,8'h00, 1,0,8'h30,0, 0,0,0, 0,0, 0,0, 2));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00,0, 0,0,0, 0,0, 0,0, 2));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00,0, 0,0,0, 0,0, 0,0, 2));
        // fresh request needs the full wait again, proving wait_cnt cleared
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,8'h00, 1,0,8'h30,0, 0,0,0, 0,0, 0,0, 2));
        vecs.push_back(mk(0,1,8'h00, 1,0,8'h30,0, 1,1,0, 0,0, 0,0, 2));
        // reset in the cycle after a host read grant kills the rvalid
        vecs.push_back(mk(1,0,8'h00, 0,0,8'h00,0, 0,0,0, 0,0, 0,0, 3));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00,0, 0,0,0, 0,0, 0,0, 0));

        foreach (vecs[k]) begin
            @(negedge clk);
            preload = 1'b0;
            rst_i = vecs[k].rst;
            core_re_i = vecs[k].cre;
            core_we_i = 1'b0;
            core_addr_i = vecs[k].caddr;
            host_req_i = vecs[k].hreq;
            host_we_i = vecs[k].hwe;
            host_addr_i = vecs[k].haddr;
            host_wdata_i = vecs[k].hwd;
            #1;
            n_vec++;
            check($sformatf("v%0d gnt", k), 64'(host_gnt_o), 64'(vecs[k].e_gnt));
            check($sformatf("v%0d stall", k), 64'(core_stall_o), 64'(vecs[k].e_stall));
            check($sformatf("v%0d rvalid", k), 64'(host_rvalid_o), 64'(vecs[k].e_rv));
            check($sformatf("v%0d force_cnt", k), 64'(force_cnt_o), 64'(vecs[k].e_fc));
            if (vecs[k].chk_hd)
                check($sformatf("v%0d host_rdata", k), host_rdata_o, vecs[k].e_hd);
            if (vecs[k].chk_cd)
                check($sformatf("v%0d core_rdata", k), core_rdata_o, vecs[k].e_cd);
        end

        // five forced host writes against core writes; CNT_W=2 copy saturates
        for (int s = 1; s <= 5; s++) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                rst_i = 1'b0;
                core_re_i = 1'b0;
                core_we_i = 1'b1;
                core_addr_i = 8'h40;
                core_wdata_i = 64'h1;
                host_req_i = 1'b1;
                host_we_i = 1'b1;
                host_addr_i = 8'h50;
                host_wdata_i = 64'(s);
                #1;
                n_vec++;
                check($sformatf("sat%0d c%0d gnt", s, c), 64'(host_gnt_o),
                      (c == 4) ? 64'h1 : 64'h0);
                check($sformatf("sat%0d c%0d stall", s, c), 64'(core_stall_o),
                      (c == 4) ? 64'h1 : 64'h0);
            end
            @(negedge clk);
            core_we_i = 1'b0;
            host_req_i = 1'b0;
            #1;
            n_vec++;
            check($sformatf("sat%0d stall_drop", s), 64'(core_stall_o), 64'h0);
            check($sformatf("sat%0d rvalid", s), 64'(host_rvalid_o), 64'h0);
            check($sformatf("sat%0d force_cnt16", s), 64'(force_cnt_o), 64'(s));
            check($sformatf("sat%0d force_cnt2", s), 64'(s_force_cnt),
                  (s > 3) ? 64'h3 : 64'(s));
        end
        check("host_write_mem", mem[8'h50], 64'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory port between the pipeline MEM stage (core) and a host/debug port used for program-data preload and inspection.
- Sits between the EXMEM outputs and data_memory.
- The core has priority. The host is served in idle memory slots; if the host is starved, it takes one forced slot while the core is stalled.
- Tracks the read owner so registered read data reaches the correct requester.

Parameters:
- ADDR_W, 8, memory address width (matches the dmem address slice [7:0]).
- DATA_W, 64, data word width.
- MAX_WAIT, 4, host-pending cycles tolerated before a forced slot (legal range 1..255).
- CNT_W, 16, width of the forced-stall performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- core_re_i  in  1  MEM-stage read enable.
- core_we_i  in  1  MEM-stage write enable.
- core_addr_i  in  ADDR_W  MEM-stage address.
- core_wdata_i  in  DATA_W  MEM-stage write data.
- core_rdata_o  out  DATA_W  read data to the WB mux.
- core_stall_o  out  1  freeze the pipeline this cycle; the core must hold its request.
- host_req_i  in  1  host request; held until granted.
- host_we_i  in  1  1 = write, 0 = read.
- host_addr_i  in  ADDR_W  host address.
- host_wdata_i  in  DATA_W  host write data.
- host_gnt_o  out  1  request accepted this cycle (single-cycle pulse).
- host_rvalid_o  out  1  host read data valid (cycle after the grant).
- host_rdata_o  out  DATA_W  host read data.
- mem_re_o  out  1  to data_memory.
- mem_we_o  out  1  to data_memory.
- mem_addr_o  out  ADDR_W  to data_memory.
- mem_wdata_o  out  DATA_W  to data_memory.
- mem_rdata_i  in  DATA_W  from data_memory; valid 1 cycle after mem_re_o.
- force_cnt_o  out  CNT_W  number of forced host slots; saturates.

Behaviour:
- Reset: state CORE_OWN, wait_cnt=0, rd_owner=CORE, host_rvalid_o=0, force_cnt_o=0. host_gnt_o=0 and core_stall_o=0 while rst_i=1. Reset mid-access drops any pending host read; no rvalid is issued.
- core_busy = core_re_i | core_we_i.
- FSM states:
  - CORE_OWN: host_req_i=0, or the host was just granted.
  - HOST_WAIT: host_req_i=1 and blocked by core_busy; wait_cnt increments each blocked cycle.
  - HOST_FORCE: one cycle; host owns the port and core_stall_o=1.
- Transitions:
  - CORE_OWN → HOST_WAIT: host_req_i & core_busy.
  - CORE_OWN → CORE_OWN (free-slot grant): host_req_i & !core_busy grants the host combinationally the same cycle, no stall.
  - HOST_WAIT → CORE_OWN: free slot occurs (grant), wait_cnt cleared.
  - HOST_WAIT → HOST_FORCE: on the clock edge where wait_cnt==MAX_WAIT-1 and still blocked.
  - HOST_FORCE → CORE_OWN: always; wait_cnt cleared; force_cnt += 1, saturating at 2^CNT_W-1.
  - host_req_i deasserting in HOST_WAIT: undefined host protocol. Return to CORE_OWN and clear wait_cnt.
- Mux: mem_* are driven by the host when host_gnt_o=1, otherwise by the core. host_gnt_o=1 implies the core drives nothing onto memory.
- Read routing: rd_owner is registered on every mem_re_o. core_rdata_o = mem_rdata_i (pass-through). host_rdata_o = mem_rdata_i. host_rvalid_o is a registered copy of (host_gnt_o & !host_we_i).
- Host write: completes at the grant edge; no rvalid.
- Back-to-back host requests: allowed; the next grant is possible the cycle after a grant.
- Latency:
  - Uncontended host access: 0 cycles to grant.
  - Worst case: MAX_WAIT+1 cycles to grant.
  - Host read data: grant+1.
- Never: both requesters on the port in one cycle, or core_stall_o for more than 1 consecutive cycle.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - State typedef with the encodings CORE_OWN=2'd0, HOST_WAIT=2'd1, HOST_FORCE=2'd2.
  - Owner enum: CORE=0, HOST=1.
  - Default widths.
- One natural sub-module: sat_counter (parameterised width, increment/clear, saturating), used for both wait_cnt and force_cnt.

Test Plan:
- Reset:
  - Stimulus: hold rst_i=1 for 2 cycles with host_req_i=1 and core_re_i=1.
  - Required: host_gnt_o=0, core_stall_o=0, host_rvalid_o=0, force_cnt_o=0.
- Free slot:
  - Stimulus: core idle; host write addr 8'h10, data 64'hDEAD_BEEF, then host read addr 8'h10.
  - Required: host_gnt_o=1 in the request cycle each time; host_rvalid_o=1 the next cycle with host_rdata_o=64'hDEAD_BEEF; core_stall_o stays 0.
- Starvation:
  - Stimulus: MAX_WAIT=4; core_re_i held at 1 continuously; host read requested at cycle 0.
  - Required: HOST_WAIT for cycles 0-3; cycle 4 core_stall_o=1 and host_gnt_o=1; cycle 5 host_rvalid_o=1; force_cnt_o=1.
- Read ownership:
  - Stimulus: core read addr 8'h20 (value 64'h5) at cycle N, forced host read addr 8'h30 (value 64'h7) at cycle N+1.
  - Required: core_rdata_o=64'h5 at N+1; host_rdata_o=64'h7 with host_rvalid_o=1 at N+2.
- Host abandon and mid-operation reset:
  - Stimulus: host_req_i drops after 2 blocked cycles.
  - Required: return to CORE_OWN, no grant, no stall.
  - Stimulus: separately, rst_i asserted in the cycle after a host read grant.
  - Required: host_rvalid_o=0.
- Saturation:
  - Stimulus: CNT_W=2; 5 forced slots.
  - Required: force_cnt_o reads 3 after the 3rd forced slot and stays at 3.
